// File: rtl/pwm_multi_shadow_if.sv
// Control and output bundle for the multi-channel PWM block.
// Master drives period/duty requests; slave returns PWM pins and status.
interface pwm_multi_shadow_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic                      enable;
  logic                      load;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_start;
  logic                      update_pending;

  modport master (
    output enable, load, period, duty,
    input  pwm_out, period_start, update_pending
  );

  modport slave (
    input  enable, load, period, duty,
    output pwm_out, period_start, update_pending
  );
endinterface

// File: rtl/pwm_multi_shadow.sv
// Multi-channel PWM with shared period counter and double-buffered
// period/duty registers that take effect only at a period boundary.
module pwm_multi_shadow #(
  parameter int                  WIDTH    = 16,
  parameter int                  CHANNELS = 4,
  parameter logic [CHANNELS-1:0] INVERT   = '0
) (
  input logic             clk,
  input logic             rst,
  pwm_multi_shadow_if.slave bus_s
);

  logic [WIDTH-1:0]          r_cnt;
  logic [WIDTH-1:0]          r_sh_per;
  logic [CHANNELS*WIDTH-1:0] r_sh_duty;
  logic [WIDTH-1:0]          r_per_q;
  logic [CHANNELS*WIDTH-1:0] r_duty_q;
  logic [CHANNELS-1:0]       r_pwm;
  logic                      r_ps;
  logic                      r_pend;

  logic                      w_run;
  logic                      w_last;
  logic                      w_xfer;
  logic [WIDTH-1:0]          w_nxt_per;
  logic [CHANNELS*WIDTH-1:0] w_nxt_duty;
  logic [CHANNELS-1:0]       w_cmp;

  assign w_run  = bus_s.enable & (r_per_q != '0);
  assign w_last = w_run & (r_cnt == r_per_q - WIDTH'(1));
  // Idle tracks the shadow every cycle; running only transfers at the wrap
  assign w_xfer = ~w_run | w_last;

  assign w_nxt_per  = bus_s.load ? bus_s.period : r_sh_per;
  assign w_nxt_duty = bus_s.load ? bus_s.duty   : r_sh_duty;

  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cmp[i] = r_cnt < r_duty_q[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_sh_per  <= '0;
      r_sh_duty <= '0;
      r_per_q   <= '0;
      r_duty_q  <= '0;
      r_pwm     <= INVERT;
      r_ps      <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      if (bus_s.load) begin
        r_sh_per  <= bus_s.period;
        r_sh_duty <= bus_s.duty;
      end

      if (w_xfer) begin
        r_per_q  <= w_nxt_per;
        r_duty_q <= w_nxt_duty;
        r_pend   <= 1'b0;
      end else if (bus_s.load) begin
        r_pend   <= 1'b1;
      end

      if (w_xfer) r_cnt <= '0;
      else        r_cnt <= r_cnt + WIDTH'(1);

      r_pwm <= (w_cmp & {CHANNELS{w_run}}) ^ INVERT;
      r_ps  <= w_run & (r_cnt == '0);
    end
  end

  assign bus_s.pwm_out        = r_pwm;
  assign bus_s.period_start   = r_ps;
  assign bus_s.update_pending = r_pend;

endmodule

// File: tb/tb_pwm_multi_shadow.sv
// Directed bench for pwm_multi_shadow: WIDTH=16, 4 channels, INVERT=0010.
// Outputs sampled 1ns after each rising edge as {pending, start, pwm}.
module tb_pwm_multi_shadow;

  localparam int          W   = 16;
  localparam int          CH  = 4;
  localparam logic [3:0]  INV = 4'b0010;
  localparam logic [5:0]  IDLE = {2'b00, INV};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pwm_multi_shadow_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  pwm_multi_shadow #(
    .WIDTH(W), .CHANNELS(CH), .INVERT(INV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_s(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [5:0] got,
                     input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] obs();
    return {bus.update_pending, bus.period_start, bus.pwm_out};
  endfunction

  // Expected sample after an edge whose preceding count was c
  function automatic logic [5:0] ev(input int c,
                                    input int d0, input int d1,
                                    input int d2, input int d3,
                                    input logic up);
    logic [3:0] p;
    p = {c < d3, c < d2, c < d1, c < d0};
    return {up, c == 0, p ^ INV};
  endfunction

  task automatic set_req(input int per, input int d0, input int d1,
                         input int d2, input int d3);
    bus.period = W'(per);
    bus.duty   = {W'(d3), W'(d2), W'(d1), W'(d0)};
  endtask

  task automatic run(input string tag, input int c0, input int c1,
                     input int d0, input int d1, input int d2,
                     input int d3, input logic up);
    for (int c = c0; c <= c1; c++) begin
      tick();
      chk(tag, obs(), ev(c, d0, d1, d2, d3, up));
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    set_req(0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", obs(), IDLE);
    end

    rst = 1'b0;
    bus.enable = 1'b1;
    bus.load   = 1'b1;
    set_req(10, 3, 0, 0, 0);
    tick();
    bus.load = 1'b0;
    chk("start_idle", obs(), IDLE);
    run("duty3", 0, 9, 3, 0, 0, 0, 1'b0);
    run("duty3_b", 0, 3, 3, 0, 0, 0, 1'b0);

    set_req(10, 7, 0, 0, 0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("load_mid", obs(), ev(4, 3, 0, 0, 0, 1'b1));
    run("hold_old", 5, 8, 3, 0, 0, 0, 1'b1);
    run("pend_clr", 9, 9, 3, 0, 0, 0, 1'b0);
    run("duty7", 0, 9, 7, 0, 0, 0, 1'b0);

    run("pre_b", 0, 8, 7, 0, 0, 0, 1'b0);
    set_req(10, 5, 0, 0, 0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("load_in_b", obs(), ev(9, 7, 0, 0, 0, 1'b0));
    run("duty5", 0, 9, 5, 0, 0, 0, 1'b0);

    set_req(10, 5, 0, 12, 0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("load_edge", obs(), ev(0, 5, 0, 0, 0, 1'b1));
    run("pend5", 1, 8, 5, 0, 0, 0, 1'b1);
    run("xfer5", 9, 9, 5, 0, 0, 0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      run("d0_d12", 0, 9, 5, 0, 12, 0, 1'b0);
    end

    set_req(0, 5, 0, 12, 0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("per0_ld", obs(), ev(0, 5, 0, 12, 0, 1'b1));
    run("per0_pend", 1, 8, 5, 0, 12, 0, 1'b1);
    run("per0_xfer", 9, 9, 5, 0, 12, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("per0_idle", obs(), IDLE);
    end

    set_req(10, 3, 0, 0, 0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("restart_ld", obs(), IDLE);
    run("restart", 0, 9, 3, 0, 0, 0, 1'b0);

    run("pre_rst", 0, 5, 3, 0, 0, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", obs(), IDLE);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_clr", obs(), IDLE);
    end

    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("post_rst_ld", obs(), IDLE);
    run("pre_dis", 0, 3, 3, 0, 0, 0, 1'b0);
    bus.enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("disabled", obs(), IDLE);
    end
    bus.enable = 1'b1;
    run("reenable", 0, 9, 3, 0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
